spi_flash_arb: RTL and testbench
================================

# spi_flash_arb

Two-port arbiter and sequencer for the single SPI configuration-flash port of the iCE40 boot stub. It sits between the flash pins and two requesters: port 0 is the flash lock engine, port 1 is the boot-config reader. It grants the pins to one requester for a whole transaction, round-robin on contention. It enforces an idle guard gap with CS# high between owners, and registers the pad outputs so they are glitch-free.

## Interface
Parameters
- GAP_CYCLES, default 4: number of cycles the pads are held idle (cs_n=1, clk=0, mosi=0) after every release; legal range 1..255.
- TW, default 20: width of the grant watchdog counter. Only used when SPI_ARB_TIMEOUT_EN is defined.

Ports
- clk  in  1  system clock (12 MHz HFOSC)
- rst  in  1  reset, asynchronous, active-high
- req  in  2  request per port; held high for the whole transaction
- gnt  out  2  one-hot grant, registered
- abort  out  2  one-cycle pulse per port when its grant is revoked by the watchdog
- r0_mosi, r0_clk, r0_cs_n  in  1 each  port 0 SPI outputs
- r0_miso  out  1  port 0 MISO
- r1_mosi, r1_clk, r1_cs_n  in  1 each  port 1 SPI outputs
- r1_miso  out  1  port 1 MISO
- spi_mosi, spi_clk, spi_cs_n  out  1 each  flash pads, registered
- spi_miso  in  1  flash pad

## Operation

States
- IDLE: no owner.
  - Exactly one req set: grant that port.
  - Both req set: grant the port not in `last`.
  - On grant, `last` is set to the granted port.
- OWN: pads follow the owner's SPI signals. The non-owner's miso is 0.
  - Owner req low: go to GAP.
  - Watchdog expiry (macro only): go to GAP and pulse abort.
- GAP: the gap counter is loaded with GAP_CYCLES-1 on entry and decrements each cycle. At zero, go to IDLE. Requests are ignored during GAP.

Rules
- Owner miso is spi_miso passed through combinationally. miso of a non-owner is 0.
- A req drop while the owner's cs_n is low is legal. The pads are forced idle on the next cycle, ending the transaction.
- A requester cannot regain the bus without passing through GAP and IDLE, so a port asserting req continuously cannot starve the other.
- A new req seen during GAP waits for IDLE.
- `rst` asserted mid-transaction: all state returns to reset values asynchronously and the pads go idle immediately.

Reset values
- gnt=00, abort=00
- spi_cs_n=1, spi_clk=0, spi_mosi=0
- r0_miso=r1_miso=0
- state IDLE, last=1, so port 0 wins the first tie.

## Timing
- Grant latency: req sampled high in IDLE at edge N gives gnt high after edge N+1.
- Pad latency: pads equal the owner's signals delayed one clk while gnt is high. Owners must therefore run SPI clk at ≤ clk/2 and sample their miso accordingly.
- Release: req low at edge M gives gnt low and pads idle after edge M+1. GAP occupies GAP_CYCLES cycles, then IDLE.
- Next grant: the earliest next gnt is high GAP_CYCLES+2 cycles after the release edge.
- Back-to-back: with req[1] pending at the release of port 0, gnt[1] rises exactly GAP_CYCLES+2 cycles after port 0's req fell.

## Configuration
- SPI_ARB_TIMEOUT_EN defined: a TW-bit counter clears on grant and increments while in OWN.
  - When it reaches all-ones, the grant is revoked: gnt low, pads idle, abort[owner] pulses for one cycle, state goes to GAP.
  - The aborted port is masked from arbitration until its req has been low for at least one cycle.
- SPI_ARB_TIMEOUT_EN undefined: no counter, abort is tied to 00, and a grant lasts until req drops.

## Test plan
- Reset: assert rst mid-OWN -> gnt=00, spi_cs_n=1, spi_clk=0 and spi_mosi=0 within the same cycle, with no clk edge needed.
- Single request: req=01 at edge 10 -> gnt=01 after edge 11. Driving r0_cs_n=0 appears on spi_cs_n one cycle later. Toggling spi_miso is reflected on r0_miso while r1_miso stays 0.
- Tie after reset: req=11 -> port 0 granted first. It releases at edge M; gnt=10 after edge M+GAP_CYCLES+2 (M+6 with default), with spi_cs_n=1 throughout the gap.
- Fairness: both ports hold req continuously and each releases after 8 cycles of ownership -> grants strictly alternate 0,1,0,1 over 6 transactions.
- Early release: owner drops req while its cs_n=0 -> spi_cs_n=1 the next cycle and stays 1 for GAP_CYCLES cycles.
- Watchdog (SPI_ARB_TIMEOUT_EN, TW=4): port 1 holds req → after 15 cycles in OWN, abort=10 for one cycle and gnt=00. Port 1 is not regranted while its req stays high; a pending port 0 is granted after the gap.

Source files
------------

// File: rtl/spi_flash_arb.sv
// Two-port SPI configuration-flash arbiter: round-robin grant, idle guard gap, registered pads.
// Optional grant watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_flash_arb #(
   parameter int GAP_CYCLES = 4,
   parameter int TW         = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic [1:0] abort,
   input  logic       r0_mosi,
   input  logic       r0_clk,
   input  logic       r0_cs_n,
   output logic       r0_miso,
   input  logic       r1_mosi,
   input  logic       r1_clk,
   input  logic       r1_cs_n,
   output logic       r1_miso,
   output logic       spi_mosi,
   output logic       spi_clk,
   output logic       spi_cs_n,
   input  logic       spi_miso
);

   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

   localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

   if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("GAP_CYCLES must be in 1..255");
   end
   if (TW < 2) begin : g_bad_tw
      $error("TW must be at least 2");
   end

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic [7:0] gap_q, gap_d;
   logic [1:0] gnt_q, gnt_d;
   logic [1:0] req_q;
   logic       cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic [1:0] elig;
   logic       pick;

`ifdef SPI_ARB_TIMEOUT_EN
   // Revoke on the edge where the count would reach all-ones.
   localparam logic [TW-1:0] WD_LAST = {{(TW-1){1'b1}}, 1'b0};
   logic [TW-1:0] wd_q, wd_d;
   logic [1:0]    mask_q, mask_d;
   logic [1:0]    abort_q, abort_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q    <= '0;
         mask_q  <= '0;
         abort_q <= '0;
      end else begin
         wd_q    <= wd_d;
         mask_q  <= mask_d;
         abort_q <= abort_d;
      end
   end
   assign abort = abort_q;
`else
   assign abort = 2'b00;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         gap_q   <= '0;
         gnt_q   <= '0;
         req_q   <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
         gnt_q   <= gnt_d;
         req_q   <= req;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      gap_d   = gap_q;
      gnt_d   = gnt_q;
      pick    = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_d    = wd_q;
      abort_d = '0;
      // An aborted port stays masked until it has dropped req.
      mask_d  = mask_q & req_q;
      elig    = req_q & ~mask_q;
`else
      elig    = req_q;
`endif
      case (state_q)
         IDLE: begin
            if (|elig) begin
               pick    = (elig == 2'b11) ? ~last_q : elig[1];
               state_d = OWN;
               owner_d = pick;
               last_d  = pick;
               gnt_d   = pick ? 2'b10 : 2'b01;
`ifdef SPI_ARB_TIMEOUT_EN
               wd_d    = '0;
`endif
            end
         end
         OWN: begin
            if (!req_q[owner_q]) begin
               state_d = GAP;
               gap_d   = GAP_LOAD;
               gnt_d   = '0;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (wd_q == WD_LAST) begin
               state_d          = GAP;
               gap_d            = GAP_LOAD;
               gnt_d            = '0;
               abort_d[owner_q] = 1'b1;
               mask_d[owner_q]  = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Pads follow the next-cycle owner so grant and pad hand-off share one edge.
      cs_n_d = 1'b1;
      sclk_d = 1'b0;
      mosi_d = 1'b0;
      if (state_d == OWN) begin
         cs_n_d = owner_d ? r1_cs_n : r0_cs_n;
         sclk_d = owner_d ? r1_clk  : r0_clk;
         mosi_d = owner_d ? r1_mosi : r0_mosi;
      end
   end

   assign gnt      = gnt_q;
   assign spi_cs_n = cs_n_q;
   assign spi_clk  = sclk_q;
   assign spi_mosi = mosi_q;
   assign r0_miso  = gnt_q[0] & spi_miso;
   assign r1_miso  = gnt_q[1] & spi_miso;

endmodule

// File: tb/tb_spi_flash_arb.sv
// Self-checking bench for spi_flash_arb: grant scoreboard plus per-scenario pad/miso checks.
module tb_spi_flash_arb;

   localparam int GAP = 4;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TWP = 4;
`else
   localparam int TWP = 20;
`endif

   typedef struct {
      logic [1:0] g;
      int         c;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic [1:0] gnt, abort;
   logic       r0_mosi = 1'b0, r0_clk = 1'b0, r0_cs_n = 1'b1, r0_miso;
   logic       r1_mosi = 1'b0, r1_clk = 1'b0, r1_cs_n = 1'b1, r1_miso;
   logic       spi_mosi, spi_clk, spi_cs_n;
   logic       spi_miso = 1'b0;

   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   ev_t got_q[$];
   ev_t exp_q[$];
   logic [1:0] gnt_prev = 2'b00;

   spi_flash_arb #(.GAP_CYCLES(GAP), .TW(TWP)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .abort(abort),
      .r0_mosi(r0_mosi), .r0_clk(r0_clk), .r0_cs_n(r0_cs_n), .r0_miso(r0_miso),
      .r1_mosi(r1_mosi), .r1_clk(r1_clk), .r1_cs_n(r1_cs_n), .r1_miso(r1_miso),
      .spi_mosi(spi_mosi), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record every grant rising from 00 with the edge count it appeared after.
   always @(negedge clk) begin
      ev_t ev;
      if (rst) gnt_prev = 2'b00;
      else begin
         if (gnt_prev == 2'b00 && gnt != 2'b00) begin
            ev.g = gnt;
            ev.c = cyc;
            got_q.push_back(ev);
         end
         gnt_prev = gnt;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] g, input int c);
      ev_t ev;
      ev.g = g;
      ev.c = c;
      exp_q.push_back(ev);
   endtask

   task automatic wait_got();
      int k = 0;
      while (got_q.size() == 0 && k < 40) begin
         tick(1);
         k++;
      end
   endtask

   task automatic test_reset();
      spi_miso = 1'b1;
      tick(2);
      n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      n_cmp++; if (abort !== 2'b00) begin n_bad++; $display("FAIL reset_abort: got %b want 00", abort); end
      n_cmp++; if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
      n_cmp++; if (spi_clk !== 1'b0) begin n_bad++; $display("FAIL reset_clk: got %b want 0", spi_clk); end
      n_cmp++; if (spi_mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
      n_cmp++; if ({r1_miso, r0_miso} !== 2'b00) begin n_bad++; $display("FAIL reset_miso: got %b want 00", {r1_miso, r0_miso}); end
      spi_miso = 1'b0;
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_single();
      ev_t g, e;
      req = 2'b01;
      push_exp(2'b01, cyc + 2);
      wait_got();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; exp_q.delete(); $display("FAIL single_grant: no grant seen, want 01"); end
      else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g.g !== e.g || g.c !== e.c) begin n_bad++; $display("FAIL single_grant: got %b @%0d want %b @%0d", g.g, g.c, e.g, e.c); end
      end
      r0_cs_n = 1'b0;
      r0_mosi = 1'b1;
      #1;
      n_cmp++; if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL single_cs_early: got %b want 1", spi_cs_n); end
      tick(1);
      n_cmp++; if (spi_cs_n !== 1'b0 || spi_mosi !== 1'b1) begin n_bad++; $display("FAIL single_pads: got cs_n=%b mosi=%b want 0 1", spi_cs_n, spi_mosi); end
      spi_miso = 1'b1;
      #1;
      n_cmp++; if (r0_miso !== 1'b1 || r1_miso !== 1'b0) begin n_bad++; $display("FAIL single_miso_hi: got r0=%b r1=%b want 1 0", r0_miso, r1_miso); end
      spi_miso = 1'b0;
      #1;
      n_cmp++; if (r0_miso !== 1'b0) begin n_bad++; $display("FAIL single_miso_lo: got %b want 0", r0_miso); end
      r0_cs_n = 1'b1;
      r0_mosi = 1'b0;
      req = 2'b00;
      tick(GAP + 4);
   endtask

   task automatic test_tie();
      ev_t g, e;
      int d;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      req = 2'b11;
      push_exp(2'b01, cyc + 2);
      wait_got();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; exp_q.delete(); $display("FAIL tie_first: no grant seen, want 01"); end
      else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g.g !== e.g || g.c !== e.c) begin n_bad++; $display("FAIL tie_first: got %b @%0d want %b @%0d", g.g, g.c, e.g, e.c); end
      end
      r0_cs_n = 1'b0;
      r1_cs_n = 1'b0;
      tick(2);
      req = 2'b10;
      d = cyc;
      push_exp(2'b10, d + GAP + 3);
      for (int k = 1; k <= GAP + 2; k++) begin
         tick(1);
         if (k == 1) begin
            n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL tie_hold: got %b want 01", gnt); end
         end else begin
            n_cmp++;
            if (spi_cs_n !== 1'b1 || gnt !== 2'b00) begin
               n_bad++; $display("FAIL tie_gap: cycle %0d got cs_n=%b gnt=%b want 1 00", k, spi_cs_n, gnt);
            end
         end
      end
      tick(1);
      n_cmp++; if (spi_cs_n !== 1'b0) begin n_bad++; $display("FAIL tie_handoff_cs: got %b want 0", spi_cs_n); end
      wait_got();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; exp_q.delete(); $display("FAIL tie_second: no grant seen, want 10"); end
      else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g.g !== e.g || g.c !== e.c) begin n_bad++; $display("FAIL tie_second: got %b @%0d want %b @%0d", g.g, g.c, e.g, e.c); end
      end
      req = 2'b00;
      r0_cs_n = 1'b1;
      r1_cs_n = 1'b1;
      tick(GAP + 4);
   endtask

   task automatic test_fairness();
      ev_t g, e;
      int d, p;
      req = 2'b11;
      push_exp(2'b01, cyc + 2);
      for (int t = 0; t < 6; t++) begin
         wait_got();
         n_cmp++;
         if (got_q.size() == 0) begin
            n_bad++; exp_q.delete();
            $display("FAIL fair_grant: transaction %0d no grant seen", t);
            break;
         end
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g.g !== e.g || g.c !== e.c) begin n_bad++; $display("FAIL fair_grant: txn %0d got %b @%0d want %b @%0d", t, g.g, g.c, e.g, e.c); end
         while (cyc < g.c + 8) tick(1);
         p = t % 2;
         req[p] = 1'b0;
         d = cyc;
         if (t < 5) push_exp(p ? 2'b01 : 2'b10, d + GAP + 3);
         tick(1);
         req[p] = 1'b1;
      end
      req = 2'b00;
      tick(GAP + 4);
   endtask

   task automatic test_early_release();
      ev_t g, e;
      req = 2'b01;
      push_exp(2'b01, cyc + 2);
      wait_got();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; exp_q.delete(); $display("FAIL early_grant: no grant seen, want 01"); end
      else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g.g !== e.g || g.c !== e.c) begin n_bad++; $display("FAIL early_grant: got %b @%0d want %b @%0d", g.g, g.c, e.g, e.c); end
      end
      r0_cs_n = 1'b0;
      r0_clk = 1'b1;
      tick(1);
      n_cmp++; if (spi_cs_n !== 1'b0 || spi_clk !== 1'b1) begin n_bad++; $display("FAIL early_active: got cs_n=%b clk=%b want 0 1", spi_cs_n, spi_clk); end
      req = 2'b00;
      tick(1);
      n_cmp++; if (spi_cs_n !== 1'b0) begin n_bad++; $display("FAIL early_sample: got %b want 0", spi_cs_n); end
      for (int k = 0; k < GAP; k++) begin
         tick(1);
         n_cmp++;
         if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0) begin
            n_bad++; $display("FAIL early_idle: cycle %0d got cs_n=%b clk=%b want 1 0", k, spi_cs_n, spi_clk);
         end
      end
      r0_cs_n = 1'b1;
      r0_clk = 1'b0;
      tick(GAP + 4);
   endtask

`ifdef SPI_ARB_TIMEOUT_EN
   task automatic test_watchdog();
      ev_t g, e;
      int gc, r, k;
      req = 2'b10;
      push_exp(2'b10, cyc + 2);
      wait_got();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; exp_q.delete(); $display("FAIL wd_grant: no grant seen, want 10"); gc = cyc; end
      else begin
         g = got_q.pop_front(); e = exp_q.pop_front(); gc = g.c;
         if (g.g !== e.g || g.c !== e.c) begin n_bad++; $display("FAIL wd_grant: got %b @%0d want %b @%0d", g.g, g.c, e.g, e.c); end
      end
      k = 0;
      while (abort === 2'b00 && k < 40) begin tick(1); k++; end
      r = cyc;
      n_cmp++; if (r !== gc + 15) begin n_bad++; $display("FAIL wd_time: abort after edge %0d want %0d", r, gc + 15); end
      n_cmp++; if (abort !== 2'b10 || gnt !== 2'b00) begin n_bad++; $display("FAIL wd_abort: got abort=%b gnt=%b want 10 00", abort, gnt); end
      req = 2'b11;
      push_exp(2'b01, r + GAP + 1);
      tick(1);
      n_cmp++; if (abort !== 2'b00) begin n_bad++; $display("FAIL wd_pulse: got %b want 00", abort); end
      wait_got();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; exp_q.delete(); $display("FAIL wd_regrant: no grant seen, want 01"); end
      else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g.g !== e.g || g.c !== e.c) begin n_bad++; $display("FAIL wd_regrant: got %b @%0d want %b @%0d", g.g, g.c, e.g, e.c); end
      end
      req = 2'b00;
      tick(GAP + 6);
      got_q.delete();
   endtask
`endif

   task automatic test_reset_mid();
      ev_t g, e;
      req = 2'b10;
      push_exp(2'b10, cyc + 2);
      wait_got();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; exp_q.delete(); $display("FAIL mid_grant: no grant seen, want 10"); end
      else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         if (g.g !== e.g || g.c !== e.c) begin n_bad++; $display("FAIL mid_grant: got %b @%0d want %b @%0d", g.g, g.c, e.g, e.c); end
      end
      r1_cs_n = 1'b0;
      r1_clk = 1'b1;
      r1_mosi = 1'b1;
      spi_miso = 1'b1;
      tick(1);
      n_cmp++;
      if (spi_cs_n !== 1'b0 || spi_clk !== 1'b1 || spi_mosi !== 1'b1 || r1_miso !== 1'b1 || r0_miso !== 1'b0) begin
         n_bad++; $display("FAIL mid_active: got cs_n=%b clk=%b mosi=%b r1_miso=%b r0_miso=%b want 0 1 1 1 0",
                           spi_cs_n, spi_clk, spi_mosi, r1_miso, r0_miso);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL mid_rst_gnt: got %b want 00", gnt); end
      n_cmp++;
      if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0 || spi_mosi !== 1'b0) begin
         n_bad++; $display("FAIL mid_rst_pads: got cs_n=%b clk=%b mosi=%b want 1 0 0", spi_cs_n, spi_clk, spi_mosi);
      end
      n_cmp++; if (r1_miso !== 1'b0) begin n_bad++; $display("FAIL mid_rst_miso: got %b want 0", r1_miso); end
      req = 2'b00;
      r1_cs_n = 1'b1;
      r1_clk = 1'b0;
      r1_mosi = 1'b0;
      spi_miso = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(2);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_fairness();
      test_early_release();
`ifdef SPI_ARB_TIMEOUT_EN
      test_watchdog();
`endif
      test_reset_mid();
      n_cmp++;
      if (got_q.size() != 0) begin n_bad++; $display("FAIL stray_grants: %0d unexpected grants seen, want 0", got_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
